// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS generator / BER checker: checker FSM encoding and the
// LFSR parity and next-state helpers (operands are zero-extended to PRBS_MAX_W).
package prbs_pkg;

    localparam int unsigned PRBS_MAX_W = 64;

    typedef enum logic [1:0] {
        StHunt,
        StVerify,
        StLocked
    } rx_state_e;

    function automatic logic prbs_fb(input logic [PRBS_MAX_W-1:0] state,
                                     input logic [PRBS_MAX_W-1:0] taps);
        return ^(state & taps);
    endfunction

    function automatic logic [PRBS_MAX_W-1:0] prbs_next(input logic [PRBS_MAX_W-1:0] state,
                                                        input logic [PRBS_MAX_W-1:0] taps);
        return {state[PRBS_MAX_W-2:0], prbs_fb(state, taps)};
    endfunction

endpackage

// File: rtl/prbs_lfsr.sv
// Fibonacci LFSR register. When enabled it shifts left, inserting either its own feedback
// or an externally supplied bit at the LSB. fb_o is the bit the register would generate next.
module prbs_lfsr
    import prbs_pkg::*;
#(
    parameter int unsigned W    = 7,
    parameter logic [W-1:0] TAPS = '0,
    parameter logic [W-1:0] SEED = '0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic ext_sel_i,
    input  logic ext_bit_i,
    output logic fb_o
);

    logic [W-1:0] state_q, state_d;

    always_comb begin
        fb_o    = prbs_fb(PRBS_MAX_W'(state_q), PRBS_MAX_W'(TAPS));
        state_d = state_q;
        if (en_i) begin
            if (ext_sel_i) begin
                state_d = {state_q[W-2:0], ext_bit_i};
            end else begin
                state_d = W'(prbs_next(PRBS_MAX_W'(state_q), PRBS_MAX_W'(TAPS)));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/prbs_ber_tester.sv
// PRBS source plus self-synchronising BER checker. The checker hunts for LFSR_W received bits,
// verifies LOCK_CNT predictions, then free-runs its own reference and counts bit errors.
module prbs_ber_tester
    import prbs_pkg::*;
#(
    parameter int unsigned LFSR_W   = 7,
    parameter logic [LFSR_W-1:0] TAPS = 7'b1100000,
    parameter logic [LFSR_W-1:0] SEED = 7'h7F,
    parameter int unsigned LOCK_CNT = 16,
    parameter int unsigned WIN      = 64,
    parameter int unsigned LOSS_THR = 8,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tx_en,
    input  logic             tx_ready,
    input  logic             err_inject,
    output logic             tx_valid,
    output logic             tx_bit,
    input  logic             rx_valid,
    input  logic             rx_bit,
    input  logic             clr,
    output logic             locked,
    output logic [CNT_W-1:0] bit_count,
    output logic [CNT_W-1:0] err_count
);

    localparam int unsigned FILL_MAX = (LFSR_W > LOCK_CNT) ? LFSR_W : LOCK_CNT;
    localparam int unsigned FC_W     = $clog2(FILL_MAX + 1);
    localparam int unsigned WC_W     = $clog2(WIN + 1);

    // Tx path
    logic tx_valid_q, tx_valid_d;
    logic inj_q, inj_d;
    logic tx_fb;
    logic tx_accept;

    assign tx_accept = tx_valid_q & tx_ready;

    prbs_lfsr #(
        .W    (LFSR_W),
        .TAPS (TAPS),
        .SEED (SEED)
    ) u_tx_lfsr (
        .clk       (clk),
        .rst_n     (reset),
        .en_i      (tx_accept),
        .ext_sel_i (1'b0),
        .ext_bit_i (1'b0),
        .fb_o      (tx_fb)
    );

    always_comb begin
        tx_valid_d = tx_en;
        inj_d      = inj_q;
        if (tx_accept) begin
            inj_d = 1'b0;
        end
        // A same-cycle inject arms the following bit rather than the one being accepted.
        if (err_inject) begin
            inj_d = 1'b1;
        end
    end

    assign tx_valid = tx_valid_q;
    assign tx_bit   = tx_fb ^ inj_q;

    // Rx checker
    rx_state_e        state_q, state_d;
    logic [FC_W-1:0]  fill_q, fill_d;
    logic [FC_W-1:0]  match_q, match_d;
    logic [WC_W-1:0]  win_cnt_q, win_cnt_d;
    logic [WC_W-1:0]  win_err_q, win_err_d;
    logic [CNT_W-1:0] bit_count_q, bit_count_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic             locked_q, locked_d;
    logic             rx_pred;
    logic             mismatch;

    // Outside LOCKED the reference tracks the line; once locked it free-runs on its prediction.
    prbs_lfsr #(
        .W    (LFSR_W),
        .TAPS (TAPS),
        .SEED ('0)
    ) u_rx_lfsr (
        .clk       (clk),
        .rst_n     (reset),
        .en_i      (rx_valid),
        .ext_sel_i (state_q != StLocked),
        .ext_bit_i (rx_bit),
        .fb_o      (rx_pred)
    );

    assign mismatch = rx_bit ^ rx_pred;

    always_comb begin
        state_d     = state_q;
        fill_d      = fill_q;
        match_d     = match_q;
        win_cnt_d   = win_cnt_q;
        win_err_d   = win_err_q;
        bit_count_d = bit_count_q;
        err_count_d = err_count_q;

        if (rx_valid) begin
            unique case (state_q)
                StHunt: begin
                    fill_d = fill_q + FC_W'(1);
                    if (fill_q == FC_W'(LFSR_W - 1)) begin
                        state_d = StVerify;
                        match_d = '0;
                    end
                end
                StVerify: begin
                    if (!mismatch) begin
                        match_d = match_q + FC_W'(1);
                        if (match_q == FC_W'(LOCK_CNT - 1)) begin
                            state_d   = StLocked;
                            win_cnt_d = '0;
                            win_err_d = '0;
                        end
                    end else begin
                        state_d = StHunt;
                        fill_d  = '0;
                    end
                end
                StLocked: begin
                    if (bit_count_q != '1) begin
                        bit_count_d = bit_count_q + CNT_W'(1);
                    end
                    if (mismatch && (err_count_q != '1)) begin
                        err_count_d = err_count_q + CNT_W'(1);
                    end
                    if (win_cnt_q == WC_W'(WIN - 1)) begin
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end else begin
                        win_cnt_d = win_cnt_q + WC_W'(1);
                        win_err_d = win_err_q + WC_W'(mismatch);
                    end
                    if (mismatch && ((win_err_q + WC_W'(1)) == WC_W'(LOSS_THR))) begin
                        state_d = StHunt;
                        fill_d  = '0;
                    end
                end
                default: begin
                    state_d = StHunt;
                    fill_d  = '0;
                end
            endcase
        end

        if (clr) begin
            bit_count_d = '0;
            err_count_d = '0;
        end

        locked_d = (state_d == StLocked);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_valid_q  <= 1'b0;
            inj_q       <= 1'b0;
            state_q     <= StHunt;
            fill_q      <= '0;
            match_q     <= '0;
            win_cnt_q   <= '0;
            win_err_q   <= '0;
            bit_count_q <= '0;
            err_count_q <= '0;
            locked_q    <= 1'b0;
        end else begin
            tx_valid_q  <= tx_valid_d;
            inj_q       <= inj_d;
            state_q     <= state_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            win_cnt_q   <= win_cnt_d;
            win_err_q   <= win_err_d;
            bit_count_q <= bit_count_d;
            err_count_q <= err_count_d;
            locked_q    <= locked_d;
        end
    end

    assign locked    = locked_q;
    assign bit_count = bit_count_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_prbs_ber_tester.sv
// Loopback bench for prbs_ber_tester: a default instance plus a CNT_W=4 instance sharing stimulus.
// Stimulus queues expected values; a negedge monitor pops and compares them.
module tb_prbs_ber_tester;

    logic clk;
    logic reset;
    logic tx_en, tx_ready, err_inject, clr;
    logic loop_en, flip;
    logic tx_valid, tx_bit, locked;
    logic [31:0] bit_count, err_count;
    logic rx_valid, rx_bit;
    logic tx_valid_s, tx_bit_s, locked_s;
    logic [3:0] bit_count_s, err_count_s;

    assign rx_valid = tx_valid & tx_ready & loop_en;
    assign rx_bit   = tx_bit ^ flip;

    prbs_ber_tester u_dut (
        .clk        (clk),
        .reset      (reset),
        .tx_en      (tx_en),
        .tx_ready   (tx_ready),
        .err_inject (err_inject),
        .tx_valid   (tx_valid),
        .tx_bit     (tx_bit),
        .rx_valid   (rx_valid),
        .rx_bit     (rx_bit),
        .clr        (clr),
        .locked     (locked),
        .bit_count  (bit_count),
        .err_count  (err_count)
    );

    prbs_ber_tester #(.CNT_W(4)) u_sat (
        .clk        (clk),
        .reset      (reset),
        .tx_en      (tx_en),
        .tx_ready   (tx_ready),
        .err_inject (err_inject),
        .tx_valid   (tx_valid_s),
        .tx_bit     (tx_bit_s),
        .rx_valid   (rx_valid),
        .rx_bit     (rx_bit),
        .clr        (clr),
        .locked     (locked_s),
        .bit_count  (bit_count_s),
        .err_count  (err_count_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef enum int {KLocked, KBit, KErr, KTxValid, KSatBit, KSatErr, KSatLocked, KSatTx} kind_e;
    typedef struct {
        kind_e       kind;
        logic [31:0] exp;
        string       name;
    } chk_t;

    chk_t chk_q[$];
    logic tx_q[$];
    logic hist[127];
    int   n_tx;
    int   n_rx;
    int   n_vec;
    int   n_bad;

    always @(posedge clk or negedge reset) begin
        if (!reset) n_rx <= 0;
        else if (rx_valid) n_rx <= n_rx + 1;
    end

    function automatic logic [31:0] obs(kind_e k);
        case (k)
            KLocked:    return {31'd0, locked};
            KBit:       return bit_count;
            KErr:       return err_count;
            KTxValid:   return {31'd0, tx_valid};
            KSatBit:    return {28'd0, bit_count_s};
            KSatErr:    return {28'd0, err_count_s};
            KSatLocked: return {31'd0, locked_s};
            default:    return {31'd0, tx_bit_s};
        endcase
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: tx bits on each accept, then any queued status checks.
    initial begin
        chk_t c;
        logic e;
        n_tx = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                n_tx = 0;
            end else if (tx_valid && tx_ready) begin
                if (tx_q.size() > 0) begin
                    e = tx_q.pop_front();
                    check("tx_bit", {31'd0, tx_bit}, {31'd0, e});
                end
                if (n_tx < 127) hist[n_tx] = tx_bit;
                else if (n_tx < 254) check("tx_period127", {31'd0, tx_bit}, {31'd0, hist[n_tx-127]});
                n_tx++;
            end
            while (chk_q.size() > 0) begin
                c = chk_q.pop_front();
                check(c.name, obs(c.kind), c.exp);
            end
        end
    end

    task automatic expect_v(kind_e k, logic [31:0] v, string name);
        chk_t c;
        c.kind = k;
        c.exp  = v;
        c.name = name;
        chk_q.push_back(c);
    endtask

    task automatic push_seed_bits();
        logic [6:0] first7;
        first7 = 7'b0000001;
        for (int i = 6; i >= 0; i--) tx_q.push_back(first7[i]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rx(int target, string name);
        int guard;
        guard = 0;
        while (n_rx < target && guard < 5000) begin
            tick();
            guard++;
        end
        if (n_rx != target) begin
            n_vec++;
            n_bad++;
            $display("FAIL wait_%s: got %0d rx bits, expected %0d", name, n_rx, target);
        end
    endtask

    task automatic wait_lock(string name);
        int guard;
        guard = 0;
        while (!locked && guard < 200) begin
            tick();
            guard++;
        end
        n_vec++;
        if (!locked) begin
            n_bad++;
            $display("FAIL %s: got locked=0, expected 1 within 200 cycles", name);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        n_vec = 0;
        n_bad = 0;
        reset = 1'b0;
        tx_en = 1'b0;
        tx_ready = 1'b0;
        err_inject = 1'b0;
        clr = 1'b0;
        loop_en = 1'b0;
        flip = 1'b0;

        repeat (2) tick();
        expect_v(KLocked, 0, "rst_locked");
        expect_v(KBit, 0, "rst_bit_count");
        expect_v(KErr, 0, "rst_err_count");
        expect_v(KTxValid, 0, "rst_tx_valid");

        @(negedge clk);
        #1;
        reset = 1'b1;
        tx_en = 1'b1;
        tx_ready = 1'b1;
        loop_en = 1'b1;
        push_seed_bits();
        tick();
        expect_v(KTxValid, 1, "tx_valid_2nd_cycle");

        // Lock after exactly 7 fill + 16 verify bits
        wait_rx(22, "pre_lock");
        expect_v(KLocked, 0, "locked_after_22");
        wait_rx(23, "lock");
        expect_v(KLocked, 1, "locked_after_23");
        expect_v(KSatLocked, 1, "sat_locked_after_23");
        expect_v(KBit, 0, "bit_count_at_lock");

        wait_rx(43, "sat20");
        expect_v(KBit, 20, "bit_count_20");
        expect_v(KSatBit, 15, "sat_bit_count_20");

        wait_rx(1023, "run1000");
        expect_v(KBit, 1000, "bit_count_1000");
        expect_v(KErr, 0, "err_count_clean");
        expect_v(KSatBit, 15, "sat_bit_count_1000");

        // Single injected tx error is counted exactly once
        err_inject = 1'b1;
        tick();
        err_inject = 1'b0;
        wait_rx(1043, "inject");
        expect_v(KErr, 1, "err_count_single");
        expect_v(KSatErr, 1, "sat_err_count_single");
        expect_v(KLocked, 1, "locked_after_single");
        expect_v(KBit, 1020, "bit_count_1020");

        // clr wins over the bit presented in the same cycle
        clr = 1'b1;
        tick();
        clr = 1'b0;
        expect_v(KBit, 0, "clr_bit_count");
        expect_v(KErr, 0, "clr_err_count");
        expect_v(KSatBit, 0, "clr_sat_bit_count");
        wait_rx(1054, "post_clr");
        expect_v(KBit, 10, "bit_count_after_clr");
        expect_v(KSatBit, 10, "sat_bit_count_after_clr");

        // Every 4th bit corrupted: 8th error in the window drops lock
        base = n_rx;
        for (int k = 1; k <= 32; k++) begin
            flip = (k % 4 == 0);
            tick();
            if (k == 31) expect_v(KLocked, 1, "locked_after_7_errs");
        end
        flip = 1'b0;
        expect_v(KLocked, 0, "locked_after_8_errs");
        expect_v(KBit, 42, "bit_count_at_loss");
        expect_v(KErr, 8, "err_count_at_loss");
        repeat (5) tick();
        expect_v(KBit, 42, "bit_count_frozen");
        expect_v(KErr, 8, "err_count_frozen");
        expect_v(KSatBit, 15, "sat_bit_count_frozen");
        expect_v(KSatErr, 8, "sat_err_count_frozen");
        if (n_rx != base + 37) begin
            n_vec++;
            n_bad++;
            $display("FAIL loss_bits: got %0d, expected %0d", n_rx - base, 37);
        end

        wait_lock("relock_after_loss");
        repeat (5) tick();

        // Async reset between edges
        @(posedge clk);
        #3;
        reset = 1'b0;
        expect_v(KLocked, 0, "async_rst_locked");
        expect_v(KBit, 0, "async_rst_bit_count");
        expect_v(KErr, 0, "async_rst_err_count");
        expect_v(KTxValid, 0, "async_rst_tx_valid");
        expect_v(KSatBit, 0, "async_rst_sat_bit_count");
        tx_q.delete();
        push_seed_bits();
        #4;
        reset = 1'b1;
        wait_rx(22, "pre_relock");
        expect_v(KLocked, 0, "relock_after_22");
        wait_rx(23, "relock");
        expect_v(KLocked, 1, "relock_after_23");

        @(negedge clk);
        #1;
        if (chk_q.size() != 0 || tx_q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: got %0d pending, expected 0", chk_q.size() + tx_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
